atm_session_ctrl: RTL and testbench
===================================

Name: atm_session_ctrl

Overview:
- Sequences one ATM transaction from debounced, edge-detected front-panel button pulses: PIN entry, PIN verify with lockout, amount entry, balance check, then a req/ack handshake with the cash-dispense block.
- Owns the BCD digit-edit register and cursor.
- Sits between the button debounce/edge stage and the seven-segment display mux and dispenser.

Parameters:
- PIN_DIGITS, 4, number of BCD digits in the PIN.
- NUM_DIGITS, 8, number of BCD digits in the amount and display register (PIN_DIGITS <= NUM_DIGITS).
- MAX_TRIES, 3, failed PIN attempts before lockout.
- TIMEOUT_CYCLES, 1000000, idle cycles in PIN/AMOUNT before the session is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  button-accept enable
- btn_pulse  in  5  single-cycle pulses {CENTER,DOWN,UP,RIGHT,LEFT} as bits [4:0]
- pin_ref  in  4*PIN_DIGITS  stored PIN, BCD, digit 0 in LSBs
- balance  in  4*NUM_DIGITS  account balance, BCD
- disp_ack  in  1  dispenser acknowledge
- disp_digits  out  4*NUM_DIGITS  digits to the display mux
- cursor  out  3  selected digit index (0 = rightmost)
- state_o  out  3  current state encoding
- disp_req  out  1  dispense request
- disp_amount  out  4*NUM_DIGITS  amount being dispensed
- err_pulse  out  1  one-cycle error strobe
- locked  out  1  lockout indicator

Behaviour:
- Decided: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: all outputs 0; state IDLE; digit register, cursor, try counter and timer all 0.
- btn_pulse is acted on only when en=1 and exactly one bit is set. Multi-hot and zero inputs are ignored.
- With en=0:
  - state, digits and timer are held;
  - the DISPENSE handshake still completes.
- States and encodings: IDLE=0, PIN=1, VERIFY=2, AMOUNT=3, CHECK=4, DISPENSE=5, LOCKED=6.
- IDLE:
  - CENTER -> PIN; digits cleared, cursor=0.
  - Other buttons are ignored.
- PIN/AMOUNT editing. LIMIT = PIN_DIGITS in PIN, NUM_DIGITS in AMOUNT.
  - LEFT: cursor+1, wrapping LIMIT-1 -> 0.
  - RIGHT: cursor-1, wrapping 0 -> LIMIT-1.
  - UP: digit[cursor]+1, wrapping 9 -> 0.
  - DOWN: digit[cursor]-1, wrapping 0 -> 9.
  - Edits take effect on the cycle after the pulse.
  - CENTER: PIN -> VERIFY, AMOUNT -> CHECK.
- VERIFY (exactly 1 cycle): compare the low PIN_DIGITS digits with pin_ref.
  - Match -> AMOUNT: digits cleared, cursor=0, tries=0.
  - Mismatch: err_pulse=1 and tries+1.
    - If tries+1 == MAX_TRIES -> LOCKED.
    - Otherwise -> PIN, with digits cleared and cursor=0.
- CHECK (exactly 1 cycle): the amount is compared as an unsigned vector (valid BCD orders like binary).
  - amount==0 or amount>balance: err_pulse=1 -> AMOUNT, digits and cursor retained.
  - Otherwise: latch disp_amount, set disp_req=1 -> DISPENSE.
- DISPENSE:
  - disp_req is held high until the first cycle disp_ack=1 is sampled.
  - On that cycle: next cycle disp_req=0 -> IDLE, digits cleared, disp_amount retained.
  - Buttons are ignored. No timeout applies.
- LOCKED: locked=1; all inputs ignored; exits only on rst.
- Timeout:
  - The timer counts in PIN and AMOUNT only, and clears on any accepted button.
  - When the timer reaches TIMEOUT_CYCLES-1 -> IDLE, digits cleared, no err_pulse.
  - The try counter is retained across timeout. It clears only on rst or a successful VERIFY.
- Simultaneous events:
  - Timeout expiry and an accepted button in the same cycle: the button wins and the timer clears.
  - rst overrides everything, including an in-flight DISPENSE.
- disp_digits carries the digit register unmodified, except when the Optional Feature below is compiled in.
- disp_digits is registered: 1-cycle latency from edit.

Optional Feature:
- Macro: ATM_PIN_MASK_EN.
- Defined: in PIN state, every digit position except cursor drives 4'hA (dash code) on disp_digits. All other states are unchanged.
- Undefined: raw PIN digits are displayed. Internal comparison is identical either way.

Test Plan:
- Reset, CENTER, then UP x3, LEFT, UP x1 -> state_o=1; disp_digits[7:0]=8'h13; cursor=1.
- pin_ref=16'h1234. Enter 1234 and press CENTER -> VERIFY for one cycle, then state_o=3; digits=0; tries=0; no err_pulse.
- Wrong PIN entered 3 times, MAX_TRIES=3 -> err_pulse on each attempt; locked=1 after the third; further buttons have no effect until rst.
- balance=32'h00000500. Amount 0600 then CENTER -> err_pulse, state stays 3.
  - Change the amount to 0500 and press CENTER -> disp_req=1, disp_amount=32'h00000500.
  - Assert disp_ack on cycle 4 -> disp_req=0 the next cycle, state_o=0.
- TIMEOUT_CYCLES=16 in PIN, no buttons -> IDLE after 16 cycles.
  - Button on cycle 10 -> timeout occurs 16 cycles after that button instead.
- Cursor wrap: in PIN press RIGHT at cursor=0 -> cursor=3. DOWN on digit 0 -> 9. LEFT+UP hot together -> ignored.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: sequences one ATM session (PIN entry, PIN verify with
// lockout, amount entry, balance check, dispenser req/ack handshake) and owns
// the BCD digit-edit register and cursor that feed the display mux.
//
// Optional build macro ATM_PIN_MASK_EN: while in PIN, every display position
// except the cursor shows the dash code 4'hA. The internal PIN compare always
// uses the raw digits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for CENTER to start a session
// PIN      | editing PIN digits, inactivity timer running
// VERIFY   | one-cycle compare of entered PIN against pin_ref
// AMOUNT   | editing amount digits, inactivity timer running
// CHECK    | one-cycle amount check against balance
// DISPENSE | disp_req held high until disp_ack is sampled
// LOCKED   | too many bad PINs; only rst leaves this state
module atm_session_ctrl #(
  parameter int PIN_DIGITS     = 4,
  parameter int NUM_DIGITS     = 8,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4:0]              btn_pulse,
  input  logic [4*PIN_DIGITS-1:0] pin_ref,
  input  logic [4*NUM_DIGITS-1:0] balance,
  input  logic                    disp_ack,
  output logic [4*NUM_DIGITS-1:0] disp_digits,
  output logic [2:0]              cursor,
  output logic [2:0]              state_o,
  output logic                    disp_req,
  output logic [4*NUM_DIGITS-1:0] disp_amount,
  output logic                    err_pulse,
  output logic                    locked
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = 4 * PIN_DIGITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(MAX_TRIES + 1);

  localparam logic [2:0]    PIN_LAST = 3'(PIN_DIGITS - 1);
  localparam logic [2:0]    NUM_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TRY_MAX  = CW'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PIN      = 3'd1,
    S_VERIFY   = 3'd2,
    S_AMOUNT   = 3'd3,
    S_CHECK    = 3'd4,
    S_DISPENSE = 3'd5,
    S_LOCKED   = 3'd6
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] digits_q, digits_n;
  logic [2:0]    cursor_q, cursor_n;
  logic [CW-1:0] tries_q, tries_n, tries_inc;
  logic [TW-1:0] timer_q, timer_n;
  logic          req_q, req_n;
  logic [DW-1:0] amt_q, amt_n;
  logic          err_q, err_n;
  logic [DW-1:0] disp_q, disp_n;
  logic [2:0]    lim;

  // A button counts only when enabled and exactly one pulse bit is set.
  logic btn_ok, btn_left, btn_right, btn_up, btn_down, btn_center;
  assign btn_ok     = en && $onehot(btn_pulse);
  assign btn_left   = btn_ok && btn_pulse[0];
  assign btn_right  = btn_ok && btn_pulse[1];
  assign btn_up     = btn_ok && btn_pulse[2];
  assign btn_down   = btn_ok && btn_pulse[3];
  assign btn_center = btn_ok && btn_pulse[4];

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      digits_q <= '0;
      cursor_q <= '0;
      tries_q  <= '0;
      timer_q  <= '0;
      req_q    <= 1'b0;
      amt_q    <= '0;
      err_q    <= 1'b0;
      disp_q   <= '0;
    end else begin
      state    <= state_n;
      digits_q <= digits_n;
      cursor_q <= cursor_n;
      tries_q  <= tries_n;
      timer_q  <= timer_n;
      req_q    <= req_n;
      amt_q    <= amt_n;
      err_q    <= err_n;
      disp_q   <= disp_n;
    end
  end

  // Next-state, edit, timer and handshake logic.
  always_comb begin
    state_n   = state;
    digits_n  = digits_q;
    cursor_n  = cursor_q;
    tries_n   = tries_q;
    timer_n   = timer_q;
    req_n     = req_q;
    amt_n     = amt_q;
    err_n     = 1'b0;
    tries_inc = tries_q + 1'b1;
    lim       = (state == S_PIN) ? PIN_LAST : NUM_LAST;

    case (state)
      S_IDLE: begin
        if (btn_center) begin
          state_n  = S_PIN;
          digits_n = '0;
          cursor_n = '0;
        end
      end

      S_PIN, S_AMOUNT: begin
        if (!en) begin
          // everything held, including the inactivity timer
        end else if (btn_ok) begin
          // an accepted button wins over a coincident timeout
          timer_n = '0;
          if (btn_left)
            cursor_n = (cursor_q == lim) ? 3'd0 : cursor_q + 3'd1;
          if (btn_right)
            cursor_n = (cursor_q == 3'd0) ? lim : cursor_q - 3'd1;
          if (btn_up || btn_down) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (cursor_q == 3'(i))
                digits_n[4*i +: 4] = btn_up ? bcd_inc(digits_q[4*i +: 4])
                                            : bcd_dec(digits_q[4*i +: 4]);
            end
          end
          if (btn_center)
            state_n = (state == S_PIN) ? S_VERIFY : S_CHECK;
        end else if (timer_q == T_LAST) begin
          state_n  = S_IDLE;
          digits_n = '0;
          cursor_n = '0;
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end

      S_VERIFY: begin
        if (en) begin
          if (digits_q[PW-1:0] == pin_ref) begin
            state_n  = S_AMOUNT;
            digits_n = '0;
            cursor_n = '0;
            tries_n  = '0;
          end else begin
            err_n   = 1'b1;
            tries_n = tries_inc;
            if (tries_inc == TRY_MAX) begin
              state_n = S_LOCKED;
            end else begin
              state_n  = S_PIN;
              digits_n = '0;
              cursor_n = '0;
            end
          end
        end
      end

      S_CHECK: begin
        if (en) begin
          if (digits_q == '0 || digits_q > balance) begin
            err_n   = 1'b1;
            state_n = S_AMOUNT;
          end else begin
            amt_n   = digits_q;
            req_n   = 1'b1;
            state_n = S_DISPENSE;
          end
        end
      end

      S_DISPENSE: begin
        // handshake completes regardless of en
        if (disp_ack) begin
          req_n    = 1'b0;
          state_n  = S_IDLE;
          digits_n = '0;
          cursor_n = '0;
        end
      end

      S_LOCKED: begin
      end

      default: state_n = S_IDLE;
    endcase

    // The timer only runs inside an editing state; start each visit at zero.
    if (state_n != S_PIN && state_n != S_AMOUNT)
      timer_n = '0;

    disp_n = digits_n;
`ifdef ATM_PIN_MASK_EN
    if (state_n == S_PIN) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cursor_n != 3'(i))
          disp_n[4*i +: 4] = 4'hA;
      end
    end
`endif
  end

  assign disp_digits = disp_q;
  assign cursor      = cursor_q;
  assign state_o     = state;
  assign disp_req    = req_q;
  assign disp_amount = amt_q;
  assign err_pulse   = err_q;
  assign locked      = (state == S_LOCKED);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: per-feature tasks, expected results queued by
// a small bench-side model and popped when the DUT produces the result.
module tb_atm_session_ctrl;

  localparam int ND = 8;
  localparam int PD = 4;
  localparam int TO = 16;

  localparam logic [4:0] B_L = 5'b00001;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_U = 5'b00100;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_C = 5'b10000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [4:0]    btn_pulse = '0;
  logic [15:0]   pin_ref = 16'h1234;
  logic [31:0]   balance = 32'h00000500;
  logic          disp_ack = 1'b0;
  logic [31:0]   disp_digits;
  logic [2:0]    cursor;
  logic [2:0]    state_o;
  logic          disp_req;
  logic [31:0]   disp_amount;
  logic          err_pulse;
  logic          locked;

  int n_tests = 0;
  int n_fail  = 0;

  int          exp_state_q[$];
  logic [31:0] exp_amt_q[$];

  atm_session_ctrl #(
    .PIN_DIGITS(PD), .NUM_DIGITS(ND), .MAX_TRIES(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .btn_pulse(btn_pulse),
    .pin_ref(pin_ref), .balance(balance), .disp_ack(disp_ack),
    .disp_digits(disp_digits), .cursor(cursor), .state_o(state_o),
    .disp_req(disp_req), .disp_amount(disp_amount),
    .err_pulse(err_pulse), .locked(locked)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the pulse covers exactly one rising edge and the
  // task returns at the following negedge with the result visible.
  task automatic press(input logic [4:0] b);
    btn_pulse = b;
    @(negedge clk);
    btn_pulse = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; btn_pulse = '0; disp_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Enter a BCD value digit by digit from cursor 0 on a cleared register.
  task automatic enter_bcd(input logic [31:0] v, input int nd);
    for (int i = 0; i < nd; i++) begin
      repeat (int'(v[4*i +: 4])) press(B_U);
      press(B_L);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({state_o, cursor, disp_req, err_pulse, locked, disp_digits, disp_amount} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs state=%0d cursor=%0d req=%0b err=%0b lock=%0b dig=%h amt=%h, want all 0",
               state_o, cursor, disp_req, err_pulse, locked, disp_digits, disp_amount);
    end
  endtask

  task automatic test_edit();
    do_reset();
    press(B_C);
    n_tests++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL edit_enter_pin got %0d want 1", state_o); end
    repeat (3) press(B_U);
    press(B_L);
    press(B_U);
    n_tests++;
    if (disp_digits[7:0] !== 8'h13) begin n_fail++; $display("FAIL edit_digits got %h want 13", disp_digits[7:0]); end
    n_tests++;
    if (cursor !== 3'd1) begin n_fail++; $display("FAIL edit_cursor got %0d want 1", cursor); end
  endtask

  task automatic test_wrap();
    do_reset();
    press(B_C);
    press(B_R);
    n_tests++;
    if (cursor !== 3'd3) begin n_fail++; $display("FAIL wrap_right got %0d want 3", cursor); end
    press(B_L);
    n_tests++;
    if (cursor !== 3'd0) begin n_fail++; $display("FAIL wrap_left got %0d want 0", cursor); end
    press(B_D);
    n_tests++;
    if (disp_digits[3:0] !== 4'd9) begin n_fail++; $display("FAIL wrap_down got %0d want 9", disp_digits[3:0]); end
    press(B_L | B_U);
    n_tests++;
    if ({cursor, disp_digits} !== {3'd0, 32'h9}) begin
      n_fail++; $display("FAIL multihot cursor=%0d dig=%h want 0 / 00000009", cursor, disp_digits);
    end
    en = 1'b0;
    press(B_U);
    en = 1'b1;
    n_tests++;
    if (disp_digits !== 32'h9) begin n_fail++; $display("FAIL en_low_edit got %h want 00000009", disp_digits); end
    press(B_U);
    n_tests++;
    if (disp_digits[3:0] !== 4'd0) begin n_fail++; $display("FAIL wrap_up got %0d want 0", disp_digits[3:0]); end
  endtask

  task automatic test_pin_ok();
    logic [15:0] entered;
    do_reset();
    press(B_C);
    entered = 16'h1234;
    enter_bcd({16'h0, entered}, PD);
    exp_state_q.push_back((entered == pin_ref) ? 3 : 1);
    press(B_C);
    n_tests++;
    if ({state_o, err_pulse} !== {3'd2, 1'b0}) begin
      n_fail++; $display("FAIL pin_verify state=%0d err=%0b want 2/0", state_o, err_pulse);
    end
    @(negedge clk);
    n_tests++;
    if (state_o !== 3'(exp_state_q.pop_front())) begin n_fail++; $display("FAIL pin_ok_state got %0d want 3", state_o); end
    n_tests++;
    if ({disp_digits, cursor, err_pulse} !== '0) begin
      n_fail++; $display("FAIL pin_ok_clear dig=%h cursor=%0d err=%0b want 0", disp_digits, cursor, err_pulse);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    press(B_C);
    for (int k = 0; k < 3; k++) begin
      exp_state_q.push_back((k == 2) ? 6 : 1);
      press(B_C);
      n_tests++;
      if ({state_o, err_pulse} !== {3'd2, 1'b0}) begin
        n_fail++; $display("FAIL lock_verify[%0d] state=%0d err=%0b want 2/0", k, state_o, err_pulse);
      end
      @(negedge clk);
      n_tests++;
      if (state_o !== 3'(exp_state_q.pop_front()) || err_pulse !== 1'b1 || locked !== (k == 2)) begin
        n_fail++; $display("FAIL lock_try[%0d] state=%0d err=%0b lock=%0b", k, state_o, err_pulse, locked);
      end
    end
    press(B_C);
    press(B_U);
    press(B_L);
    repeat (20) @(negedge clk);
    n_tests++;
    if ({state_o, locked, err_pulse, cursor} !== {3'd6, 1'b1, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL lock_hold state=%0d lock=%0b err=%0b cursor=%0d want 6/1/0/0", state_o, locked, err_pulse, cursor);
    end
    do_reset();
    n_tests++;
    if ({state_o, locked} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL lock_rst state=%0d lock=%0b want 0/0", state_o, locked);
    end
  endtask

  task automatic amount_check(input logic [31:0] amt, input string tag);
    logic ok;
    ok = (amt != 0) && (amt <= balance);
    exp_state_q.push_back(ok ? 5 : 3);
    if (ok) exp_amt_q.push_back(amt);
    press(B_C);
    @(negedge clk);
    n_tests++;
    if (state_o !== 3'(exp_state_q[0]) || err_pulse !== !ok || disp_req !== ok) begin
      n_fail++; $display("FAIL check_%s state=%0d err=%0b req=%0b want %0d/%0b/%0b",
                         tag, state_o, err_pulse, disp_req, exp_state_q[0], !ok, ok);
    end
    void'(exp_state_q.pop_front());
    if (ok) begin
      n_tests++;
      if (disp_amount !== exp_amt_q[0]) begin n_fail++; $display("FAIL check_%s_amt got %h want %h", tag, disp_amount, exp_amt_q[0]); end
      void'(exp_amt_q.pop_front());
    end
  endtask

  task automatic test_dispense();
    do_reset();
    press(B_C);
    enter_bcd(32'h1234, PD);
    press(B_C);
    @(negedge clk);
    amount_check(32'h0, "zero");
    enter_bcd(32'h00000600, ND);
    amount_check(32'h00000600, "over");
    press(B_L);
    press(B_L);
    press(B_D);
    amount_check(32'h00000500, "equal");
    en = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (disp_req !== 1'b1 || state_o !== 3'd5) begin
        n_fail++; $display("FAIL disp_hold[%0d] req=%0b state=%0d want 1/5", c, disp_req, state_o);
      end
    end
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    en = 1'b1;
    n_tests++;
    if ({disp_req, state_o, disp_amount, disp_digits} !== {1'b0, 3'd0, 32'h00000500, 32'h0}) begin
      n_fail++; $display("FAIL disp_done req=%0b state=%0d amt=%h dig=%h want 0/0/00000500/0",
                         disp_req, state_o, disp_amount, disp_digits);
    end
  endtask

  task automatic count_to_idle(input string tag);
    int n;
    n = 0;
    while (state_o == 3'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n != TO || state_o !== 3'd0 || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL timeout_%s cycles=%0d state=%0d err=%0b want %0d/0/0", tag, n, state_o, err_pulse, TO);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    press(B_C);
    count_to_idle("idle");
    press(B_C);
    repeat (9) @(negedge clk);
    press(B_U);
    count_to_idle("btn10");
    press(B_C);
    repeat (15) @(negedge clk);
    press(B_U);
    count_to_idle("collide");
    press(B_C);
    en = 1'b0;
    repeat (30) @(negedge clk);
    n_tests++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL timeout_en_hold got %0d want 1", state_o); end
    en = 1'b1;
    count_to_idle("en_resume");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_edit();
    test_wrap();
    test_pin_ok();
    test_lockout();
    test_dispense();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
